// File: rtl/macro_reduction_gather_and_pkg.sv
// Shared types for the gather/AND-reduction stage.
// No logic; state enum plus a sizing helper.
// Not applicable (no handshakes here).
package macro_reduction_gather_and_pkg;

`include "macro_reduction_gather_and_defs.vh"

    typedef enum logic [1:0] {
        ST_GATHER = MRGA_ST_GATHER,
        ST_REDUCE = MRGA_ST_REDUCE,
        ST_OUTPUT = MRGA_ST_OUTPUT
    } state_t;

    // Tree leaf count: lane count rounded up to a power of two.
    function automatic int unsigned pad_count(input int unsigned n);
        return 32'd1 << $clog2(n);
    endfunction

endpackage

// File: rtl/macro_reduction_gather_and_defs.vh
// State encodings shared by the gather/barrier FSM.
// Pure localparams, no logic; pulled into the package.
// Encodings are fixed so waveforms decode identically across builds.
`ifndef MACRO_REDUCTION_GATHER_AND_DEFS_VH
`define MACRO_REDUCTION_GATHER_AND_DEFS_VH

localparam logic [1:0] MRGA_ST_GATHER = 2'd0;
localparam logic [1:0] MRGA_ST_REDUCE = 2'd1;
localparam logic [1:0] MRGA_ST_OUTPUT = 2'd2;

`endif

// File: rtl/macro_reduction_tree_and.sv
// Balanced bitwise-AND reduction over a power-of-two number of leaves.
// Purely combinational, zero cycles.
// No flow control; the caller owns the handshake.
module macro_reduction_tree_and #(
    parameter int INPUT_WIDTH = 1,
    parameter int INPUT_COUNT = 1
) (
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] leaves,
    output logic [INPUT_WIDTH-1:0]             result
);

    // Heap layout: node 0 is the root, leaves start at INPUT_COUNT-1.
    logic [INPUT_WIDTH-1:0] node [2*INPUT_COUNT-1];

    // Load leaves, then fold pairs upward from the deepest internal node.
    always_comb begin
        for (int i = 0; i < 2*INPUT_COUNT-1; i++) begin
            node[i] = '1;
        end
        for (int k = 0; k < INPUT_COUNT; k++) begin
            node[INPUT_COUNT-1+k] = leaves[k*INPUT_WIDTH +: INPUT_WIDTH];
        end
        for (int i = INPUT_COUNT-2; i >= 0; i--) begin
            node[i] = node[2*i+1] & node[2*i+2];
        end
    end

    assign result = node[0];

endmodule

// File: rtl/macro_reduction_gather_and.sv
// Gathers one word per lane in any order, then emits the AND of all lanes.
// Result valid right after the last capture edge (+1 cycle with MACRO_REDUCTION_GATHER_AND_OUTREG_EN).
// Lanes stall (i_ready=0) from completion until o_valid&o_ready or i_flush.
module macro_reduction_gather_and
    import macro_reduction_gather_and_pkg::*;
#(
    parameter int INPUT_WIDTH = 1,
    parameter int INPUT_COUNT = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [INPUT_COUNT-1:0]             i_valid,
    output logic [INPUT_COUNT-1:0]             i_ready,
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] i_data,
    input  logic                               i_flush,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [INPUT_WIDTH-1:0]             o_data,
    output logic [INPUT_COUNT-1:0]             o_pending
);

    localparam int PAD_COUNT = int'(pad_count(INPUT_COUNT));

    state_t                         state;
    state_t                         state_nxt;
    logic [INPUT_COUNT-1:0]         captured;
    logic [INPUT_COUNT-1:0]         captured_nxt;
    logic [INPUT_COUNT-1:0]         take;
    logic                           handshake;
    logic [INPUT_WIDTH-1:0]         lane_q [INPUT_COUNT];
    logic [INPUT_WIDTH*PAD_COUNT-1:0] tree_in;
    logic [INPUT_WIDTH-1:0]         tree_out;

    // Only uncaptured lanes are offered a slot, and only while gathering.
    assign i_ready   = (state == ST_GATHER) ? ~captured : '0;
    // Flush wins over capture even when i_ready is high.
    assign take      = i_valid & i_ready & {INPUT_COUNT{~i_flush}};
    assign o_valid   = (state == ST_OUTPUT);
    assign handshake = o_valid & o_ready;
    assign o_pending = ~captured;

    // Flag update: flush and handshake both drop every flag.
    always_comb begin
        captured_nxt = captured | take;
        if (i_flush || handshake) begin
            captured_nxt = '0;
        end
    end

    // Next state; completion is taken from the post-edge flags.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GATHER: begin
                if (!i_flush && (&captured_nxt)) begin
`ifdef MACRO_REDUCTION_GATHER_AND_OUTREG_EN
                    state_nxt = ST_REDUCE;
`else
                    state_nxt = ST_OUTPUT;
`endif
                end
            end
            ST_REDUCE: begin
                state_nxt = i_flush ? ST_GATHER : ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (i_flush || handshake) begin
                    state_nxt = ST_GATHER;
                end
            end
            default: state_nxt = ST_GATHER;
        endcase
    end

    // State and capture flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_GATHER;
            captured <= '0;
        end else begin
            state    <= state_nxt;
            captured <= captured_nxt;
        end
    end

    // Lane words are only overwritten on capture; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < INPUT_COUNT; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < INPUT_COUNT; k++) begin
                if (take[k]) begin
                    lane_q[k] <= i_data[k*INPUT_WIDTH +: INPUT_WIDTH];
                end
            end
        end
    end

    // Pack lanes into the tree; padding leaves are all-ones so they are neutral.
    always_comb begin
        tree_in = '1;
        for (int k = 0; k < INPUT_COUNT; k++) begin
            tree_in[k*INPUT_WIDTH +: INPUT_WIDTH] = lane_q[k];
        end
    end

    macro_reduction_tree_and #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .INPUT_COUNT (PAD_COUNT)
    ) u_tree (
        .leaves (tree_in),
        .result (tree_out)
    );

`ifdef MACRO_REDUCTION_GATHER_AND_OUTREG_EN
    logic [INPUT_WIDTH-1:0] o_data_q;

    // Register the tree result during REDUCE so o_data comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_data_q <= '0;
        end else if (state == ST_REDUCE) begin
            o_data_q <= tree_out;
        end
    end

    assign o_data = o_data_q;
`else
    assign o_data = tree_out;
`endif

endmodule

// File: tb/tb_macro_reduction_gather_and.sv
// Directed bench for the gather/AND-reduction stage (4-lane and 3-lane instances).
// Outputs sampled 1 time unit after the rising edge.
// Tracks completed transfers independently of the DUT to catch flush leaks.
module tb_macro_reduction_gather_and;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  v4;
    logic [3:0]  r4;
    logic [31:0] d4;
    logic        fl4;
    logic        ov4;
    logic        or4;
    logic [7:0]  od4;
    logic [3:0]  pend4;

    logic [2:0]  v3;
    logic [2:0]  r3;
    logic [23:0] d3;
    logic        fl3;
    logic        ov3;
    logic        or3;
    logic [7:0]  od3;
    logic [2:0]  pend3;

    int cmp_cnt  = 0;
    int err_cnt  = 0;
    int xfers    = 0;
    int exp_xfer = 0;

    always #5 clk = ~clk;

    macro_reduction_gather_and #(.INPUT_WIDTH(8), .INPUT_COUNT(4)) dut4 (
        .clk(clk), .reset(reset), .i_valid(v4), .i_ready(r4), .i_data(d4),
        .i_flush(fl4), .o_valid(ov4), .o_ready(or4), .o_data(od4), .o_pending(pend4)
    );

    macro_reduction_gather_and #(.INPUT_WIDTH(8), .INPUT_COUNT(3)) dut3 (
        .clk(clk), .reset(reset), .i_valid(v3), .i_ready(r3), .i_data(d3),
        .i_flush(fl3), .o_valid(ov3), .o_ready(or3), .o_data(od3), .o_pending(pend3)
    );

    // Transfer monitor: a flushed handshake is not a transfer.
    always @(posedge clk) begin
        if (!reset && ov4 && or4 && !fl4) xfers++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_reduce();
`ifdef MACRO_REDUCTION_GATHER_AND_OUTREG_EN
        step();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v4 = '0; d4 = '0; fl4 = 1'b0; or4 = 1'b0;
        v3 = '0; d3 = '0; fl3 = 1'b0; or3 = 1'b0;
        step(); step();
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL reset_o_valid: got %0b want 0", ov4); end
        cmp_cnt++; if (r4 !== 4'hF) begin err_cnt++; $display("FAIL reset_i_ready: got %h want f", r4); end
        cmp_cnt++; if (pend4 !== 4'hF) begin err_cnt++; $display("FAIL reset_pending: got %h want f", pend4); end
        cmp_cnt++; if (od4 !== 8'h00) begin err_cnt++; $display("FAIL reset_o_data: got %h want 00", od4); end
        cmp_cnt++; if (r3 !== 3'h7) begin err_cnt++; $display("FAIL reset_i_ready3: got %h want 7", r3); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_order();
        logic [7:0] vals [4];
        logic [3:0] pexp [4];
        vals[0] = 8'hFF; vals[1] = 8'hF0; vals[2] = 8'h3C; vals[3] = 8'hF4;
        pexp[0] = 4'hE;  pexp[1] = 4'hC;  pexp[2] = 4'h8;  pexp[3] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            v4 = 4'b0001 << k;
            d4[k*8 +: 8] = vals[k];
            step();
            v4 = '0;
            cmp_cnt++; if (pend4 !== pexp[k]) begin err_cnt++; $display("FAIL order_pending%0d: got %h want %h", k, pend4, pexp[k]); end
            if (k < 3) begin
                cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL order_early_valid%0d: got %0b want 0", k, ov4); end
            end
        end
        settle_reduce();
        cmp_cnt++; if (ov4 !== 1'b1) begin err_cnt++; $display("FAIL order_valid: got %0b want 1", ov4); end
        cmp_cnt++; if (od4 !== 8'h30) begin err_cnt++; $display("FAIL order_data: got %h want 30", od4); end
        cmp_cnt++; if (r4 !== 4'h0) begin err_cnt++; $display("FAIL order_i_ready: got %h want 0", r4); end
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        exp_xfer++;
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL order_after_hs_valid: got %0b want 0", ov4); end
        cmp_cnt++; if (r4 !== 4'hF) begin err_cnt++; $display("FAIL order_after_hs_ready: got %h want f", r4); end
    endtask

    task automatic test_non_pow2();
        v3 = 3'b111;
        d3 = {8'hEA, 8'hAB, 8'hAA};
        step();
        v3 = '0;
        settle_reduce();
        cmp_cnt++; if (ov3 !== 1'b1) begin err_cnt++; $display("FAIL np2_valid: got %0b want 1", ov3); end
        cmp_cnt++; if (od3 !== 8'hAA) begin err_cnt++; $display("FAIL np2_data: got %h want aa", od3); end
        or3 = 1'b1;
        step();
        or3 = 1'b0;
        cmp_cnt++; if (ov3 !== 1'b0) begin err_cnt++; $display("FAIL np2_after_hs_valid: got %0b want 0", ov3); end
        cmp_cnt++; if (r3 !== 3'h7) begin err_cnt++; $display("FAIL np2_after_hs_ready: got %h want 7", r3); end
    endtask

    task automatic test_backpressure();
        v4 = 4'hF;
        d4 = {8'h7F, 8'h3F, 8'h1F, 8'h0F};
        step();
        settle_reduce();
        // Keep lanes presenting new data while stalled; none may be captured.
        d4 = 32'h0;
        for (int c = 0; c < 5; c++) begin
            cmp_cnt++; if (ov4 !== 1'b1) begin err_cnt++; $display("FAIL bp_valid%0d: got %0b want 1", c, ov4); end
            cmp_cnt++; if (od4 !== 8'h0F) begin err_cnt++; $display("FAIL bp_data%0d: got %h want 0f", c, od4); end
            cmp_cnt++; if (r4 !== 4'h0) begin err_cnt++; $display("FAIL bp_ready%0d: got %h want 0", c, r4); end
            step();
        end
        v4 = '0;
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        exp_xfer++;
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL bp_after_valid: got %0b want 0", ov4); end
        cmp_cnt++; if (r4 !== 4'hF) begin err_cnt++; $display("FAIL bp_after_ready: got %h want f", r4); end
        cmp_cnt++; if (pend4 !== 4'hF) begin err_cnt++; $display("FAIL bp_after_pending: got %h want f", pend4); end
    endtask

    task automatic test_flush_gather();
        v4 = 4'b0011;
        d4 = {8'h00, 8'h00, 8'h22, 8'h11};
        step();
        cmp_cnt++; if (pend4 !== 4'hC) begin err_cnt++; $display("FAIL fg_pending_pre: got %h want c", pend4); end
        v4 = 4'b0100;
        fl4 = 1'b1;
        step();
        v4 = '0;
        fl4 = 1'b0;
        cmp_cnt++; if (pend4 !== 4'hF) begin err_cnt++; $display("FAIL fg_pending_post: got %h want f", pend4); end
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL fg_valid_post: got %0b want 0", ov4); end
        // Fresh gather: lanes 0,1,3 first; lane 2 must still be outstanding.
        v4 = 4'b1011;
        d4 = {8'hFF, 8'hF7, 8'hF3, 8'hF0};
        step();
        v4 = '0;
        cmp_cnt++; if (pend4 !== 4'h4) begin err_cnt++; $display("FAIL fg_pending_fresh: got %h want 4", pend4); end
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL fg_valid_fresh: got %0b want 0", ov4); end
        v4 = 4'b0100;
        step();
        v4 = '0;
        settle_reduce();
        cmp_cnt++; if (ov4 !== 1'b1) begin err_cnt++; $display("FAIL fg_valid_done: got %0b want 1", ov4); end
        cmp_cnt++; if (od4 !== 8'hF0) begin err_cnt++; $display("FAIL fg_data: got %h want f0", od4); end
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        exp_xfer++;
    endtask

    task automatic test_flush_output();
        v4 = 4'hF;
        d4 = 32'hFFFF_FFFF;
        step();
        v4 = '0;
        settle_reduce();
        cmp_cnt++; if (ov4 !== 1'b1) begin err_cnt++; $display("FAIL fo_valid_pre: got %0b want 1", ov4); end
        fl4 = 1'b1;
        or4 = 1'b1;
        step();
        fl4 = 1'b0;
        or4 = 1'b0;
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL fo_valid_post: got %0b want 0", ov4); end
        cmp_cnt++; if (r4 !== 4'hF) begin err_cnt++; $display("FAIL fo_ready_post: got %h want f", r4); end
        cmp_cnt++; if (xfers !== exp_xfer) begin err_cnt++; $display("FAIL fo_xfers: got %0d want %0d", xfers, exp_xfer); end
    endtask

    task automatic test_back_to_back();
        v4 = 4'hF;
        d4 = 32'hA5A5_A5A5;
        or4 = 1'b1;
        step();
        settle_reduce();
        cmp_cnt++; if (ov4 !== 1'b1 || od4 !== 8'hA5) begin err_cnt++; $display("FAIL b2b_first: got v=%0b d=%h want v=1 d=a5", ov4, od4); end
        d4 = 32'h5A5A_5A5A;
        step();
        exp_xfer++;
        cmp_cnt++; if (ov4 !== 1'b0 || pend4 !== 4'hF) begin err_cnt++; $display("FAIL b2b_gap: got v=%0b p=%h want v=0 p=f", ov4, pend4); end
        step();
        settle_reduce();
        cmp_cnt++; if (ov4 !== 1'b1 || od4 !== 8'h5A) begin err_cnt++; $display("FAIL b2b_second: got v=%0b d=%h want v=1 d=5a", ov4, od4); end
        v4 = '0;
        step();
        or4 = 1'b0;
        exp_xfer++;
        cmp_cnt++; if (xfers !== exp_xfer) begin err_cnt++; $display("FAIL b2b_xfers: got %0d want %0d", xfers, exp_xfer); end
    endtask

    task automatic test_reset_mid();
        v4 = 4'b0011;
        d4 = {8'h00, 8'h00, 8'hAA, 8'h55};
        step();
        v4 = '0;
        cmp_cnt++; if (pend4 !== 4'hC) begin err_cnt++; $display("FAIL rm_pending_pre: got %h want c", pend4); end
        reset = 1'b1;
        step();
        cmp_cnt++; if (ov4 !== 1'b0) begin err_cnt++; $display("FAIL rm_valid: got %0b want 0", ov4); end
        cmp_cnt++; if (pend4 !== 4'hF) begin err_cnt++; $display("FAIL rm_pending: got %h want f", pend4); end
        cmp_cnt++; if (od4 !== 8'h00) begin err_cnt++; $display("FAIL rm_data: got %h want 00", od4); end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_order();
        test_non_pow2();
        test_backpressure();
        test_flush_gather();
        test_flush_output();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
